// File: rtl/sound_player.sv
// ----------------------------------------------------------------------------
// sound_player
// Plays a short tone pattern on a buzzer pin whenever a new sound code shows
// up from the animation logic. Ping and pong are one tone phase each; go is
// a low tone phase followed by a high tone phase.
//
// Ports:
//   clk         system clock
//   clr         asynchronous active-high reset
//   code_sound  sound code: 00 stop, 01 pong, 10 ping, 11 go
//   mute        forces silence and aborts the current sound
//   trigger     one-cycle strobe that replays the current code
//   buzzer      registered square-wave output
//   busy        high while a sound is playing
//   done        one-cycle pulse when a sound completes normally
// ----------------------------------------------------------------------------
module sound_player #(
    parameter int DIV_PING  = 6818,
    parameter int DIV_PONG  = 13636,
    parameter int DIV_GO_LO = 22727,
    parameter int DIV_GO_HI = 11364,
    parameter int DUR       = 1200000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       mute,
    input  logic       trigger,
    output logic       buzzer,
    output logic       busy,
    output logic       done
);

    localparam logic [23:0] DIV_PING_W  = 24'(DIV_PING);
    localparam logic [23:0] DIV_PONG_W  = 24'(DIV_PONG);
    localparam logic [23:0] DIV_GO_LO_W = 24'(DIV_GO_LO);
    localparam logic [23:0] DIV_GO_HI_W = 24'(DIV_GO_HI);
    localparam logic [23:0] DUR_M1      = 24'(DUR - 1);

    // state | meaning
    // IDLE  | silent, waiting for a start event
    // TONE1 | ping/pong tone, or the low go tone
    // TONE2 | high go tone (go only)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TONE1 = 2'd1,
        TONE2 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  code_q;
    logic [1:0]  act_code_q, act_code_d;
    logic [23:0] div_q, div_d;
    logic [23:0] div_cnt_q, div_cnt_d;
    logic [23:0] dur_cnt_q, dur_cnt_d;
    logic        buzzer_q, buzzer_d;
    logic        done_q, done_d;

    logic        start;
    logic [23:0] start_div;

    // A trigger coinciding with a code change is still just one start.
    assign start = (code_sound != code_q) || trigger;

    always_comb begin
        start_div = DIV_PING_W;
        case (code_sound)
            2'b01:   start_div = DIV_PONG_W;
            2'b10:   start_div = DIV_PING_W;
            2'b11:   start_div = DIV_GO_LO_W;
            default: start_div = DIV_PING_W;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        act_code_d = act_code_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        buzzer_d   = buzzer_q;
        done_d     = 1'b0;

        if (mute) begin
            state_d   = IDLE;
            buzzer_d  = 1'b0;
            div_cnt_d = '0;
            dur_cnt_d = '0;
        end else if (start) begin
            div_cnt_d = '0;
            dur_cnt_d = '0;
            if (code_sound != 2'b00) begin
                state_d    = TONE1;
                act_code_d = code_sound;
                div_d      = start_div;
                buzzer_d   = 1'b1;
            end else begin
                state_d  = IDLE;
                buzzer_d = 1'b0;
            end
        end else if (state_q != IDLE) begin
            if (dur_cnt_q == DUR_M1) begin
                div_cnt_d = '0;
                dur_cnt_d = '0;
                if (state_q == TONE1 && act_code_q == 2'b11) begin
                    state_d  = TONE2;
                    div_d    = DIV_GO_HI_W;
                    buzzer_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                    buzzer_d = 1'b0;
                    done_d   = 1'b1;
                end
            end else begin
                dur_cnt_d = dur_cnt_q + 24'd1;
                if (div_cnt_q == div_q - 24'd1) begin
                    buzzer_d  = ~buzzer_q;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            code_q     <= 2'b00;
            act_code_q <= 2'b00;
            div_q      <= DIV_PING_W;
            div_cnt_q  <= '0;
            dur_cnt_q  <= '0;
            buzzer_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_sound;
            act_code_q <= act_code_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            buzzer_q   <= buzzer_d;
            done_q     <= done_d;
        end
    end

    assign buzzer = buzzer_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_sound_player.sv
module tb_sound_player;

    localparam int P_PING  = 3;
    localparam int P_PONG  = 5;
    localparam int P_GO_LO = 4;
    localparam int P_GO_HI = 2;
    localparam int P_DUR   = 20;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [1:0] code_sound = 2'b00;
    logic       mute = 1'b0;
    logic       trigger = 1'b0;
    logic       buzzer, busy, done;

    int checks = 0;
    int failures = 0;
    bit run_chk = 1'b0;

    sound_player #(
        .DIV_PING (P_PING),
        .DIV_PONG (P_PONG),
        .DIV_GO_LO(P_GO_LO),
        .DIV_GO_HI(P_GO_HI),
        .DUR      (P_DUR)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .code_sound(code_sound),
        .mute      (mute),
        .trigger   (trigger),
        .buzzer    (buzzer),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A sound is described by its code and the number of cycles elapsed since
    // it started; the buzzer level follows directly from that.
    logic [1:0] m_code_q = 2'b00;
    bit         m_active = 1'b0;
    logic [1:0] m_code   = 2'b00;
    int         m_t      = 0;
    bit         m_done   = 1'b0;

    function automatic bit pattern(input logic [1:0] c, input int t);
        int div;
        int k;
        if (c == 2'b11) begin
            if (t < P_DUR) begin div = P_GO_LO; k = t; end
            else begin div = P_GO_HI; k = t - P_DUR; end
        end else begin
            div = (c == 2'b10) ? P_PING : P_PONG;
            k = t;
        end
        return ((k / div) % 2) == 0;
    endfunction

    function automatic int sound_len(input logic [1:0] c);
        return (c == 2'b11) ? 2 * P_DUR : P_DUR;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_code_q = 2'b00;
            m_active = 1'b0;
            m_t      = 0;
            m_done   = 1'b0;
        end else begin
            bit st;
            st = (code_sound != m_code_q) || trigger;
            m_done = 1'b0;
            if (mute) begin
                m_active = 1'b0;
            end else if (st) begin
                if (code_sound != 2'b00) begin
                    m_active = 1'b1;
                    m_code   = code_sound;
                    m_t      = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_active) begin
                m_t++;
                if (m_t == sound_len(m_code)) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
            m_code_q = code_sound;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("model_buzzer", int'(buzzer), int'(m_active ? pattern(m_code, m_t) : 1'b0));
            chk("model_busy",   int'(busy),   int'(m_active));
            chk("model_done",   int'(done),   int'(m_done));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic observe(input int n, output int busy_cnt, output int done_cnt,
                           output int done_idx, output logic [63:0] buz);
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        buz = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_idx = i; end
            if (i < 64) buz[i] = buzzer;
        end
    endtask

    initial begin
        int bc, dc, di;
        logic [63:0] bz;

        #1;
        run_chk = 1'b1;
        chk("reset_buzzer", int'(buzzer), 0);
        chk("reset_busy",   int'(busy),   0);
        chk("reset_done",   int'(done),   0);
        repeat (3) @(negedge clk);
        clr = 1'b0;

        // 1: idle with code 00
        observe(50, bc, dc, di, bz);
        chk("idle_busy_cnt", bc, 0);
        chk("idle_done_cnt", dc, 0);
        chk("idle_buzzer", int'(bz[49:0] != '0), 0);

        // 2: ping
        code_sound = 2'b10;
        observe(24, bc, dc, di, bz);
        chk("ping_busy_cnt", bc, 20);
        chk("ping_done_cnt", dc, 1);
        chk("ping_done_idx", di, 20);
        chk("ping_pattern", int'(bz[11:0]), int'(12'b000111000111));
        chk("ping_after", int'(bz[23:20]), 0);

        // 3: go
        code_sound = 2'b11;
        observe(44, bc, dc, di, bz);
        chk("go_busy_cnt", bc, 40);
        chk("go_done_cnt", dc, 1);
        chk("go_done_idx", di, 40);
        chk("go_lo_pattern", int'(bz[7:0]), int'(8'b00001111));
        chk("go_hi_pattern", int'(bz[27:20]), int'(8'b00110011));

        // 4: ping interrupted by pong after 7 cycles
        code_sound = 2'b10;
        observe(7, bc, dc, di, bz);
        chk("pp_ping_busy", bc, 7);
        code_sound = 2'b01;
        observe(24, bc, dc, di, bz);
        chk("pp_pong_busy", bc, 20);
        chk("pp_done_cnt", dc, 1);
        chk("pp_done_idx", di, 20);
        chk("pp_pong_pattern", int'(bz[9:0]), int'(10'b0000011111));

        // 5: mute during pong, then trigger replay
        trigger = 1'b1;
        observe(1, bc, dc, di, bz);
        trigger = 1'b0;
        observe(9, bc, dc, di, bz);
        chk("mute_pre_busy", bc, 9);
        mute = 1'b1;
        observe(1, bc, dc, di, bz);
        chk("mute_busy", bc, 0);
        chk("mute_buzzer", int'(bz[0]), 0);
        observe(5, bc, dc, di, bz);
        mute = 1'b0;
        observe(10, bc, dc, di, bz);
        chk("unmute_busy", bc, 0);
        chk("unmute_done", dc, 0);
        trigger = 1'b1;
        observe(1, bc, dc, di, bz);
        trigger = 1'b0;
        observe(24, bc, dc, di, bz);
        chk("replay_busy", bc + 1, 20);
        chk("replay_done", dc, 1);

        // 6: async clear mid-go
        code_sound = 2'b00;
        observe(2, bc, dc, di, bz);
        code_sound = 2'b11;
        observe(10, bc, dc, di, bz);
        chk("clr_pre_busy", int'(busy), 1);
        #2 clr = 1'b1;
        #1;
        chk("clr_buzzer", int'(buzzer), 0);
        chk("clr_busy",   int'(busy),   0);
        chk("clr_done",   int'(done),   0);
        @(negedge clk);
        clr = 1'b0;
        observe(44, bc, dc, di, bz);
        chk("clr_go_busy", bc, 40);
        chk("clr_go_done", dc, 1);
        chk("clr_go_idx", di, 40);

        // random phase, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) code_sound = 2'($urandom_range(0, 3));
            trigger = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) mute = ~mute;
        end
        @(negedge clk);
        mute = 1'b0;
        trigger = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
